char_draw_ctrl: RTL and testbench

Sequences one character glyph LUT over an 8x10 cell. It converts each "draw character" request into a stream of pixel writes to the framebuffer plotter. Glyph decoders are queried by cell-relative offset through a shared lookup interface; only lit pixels are emitted (background optional). It sits between game/score logic (requesters) and the VGA plot port.

---
 rtl/char_draw_pkg.sv | 24 ++
 rtl/char_draw_if.sv | 48 ++++
 rtl/char_cell_counter.sv | 42 ++++
 rtl/char_draw_ctrl.sv | 152 +++++++++++++++
 tb/tb_char_draw_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/char_draw_pkg.sv
// Shared types and default geometry for the character draw controller.
// Optional background fill is enabled by defining CHAR_DRAW_BG_EN.
package char_draw_pkg;

    localparam int DEF_CELL_W   = 8;
    localparam int DEF_CELL_H   = 10;
    localparam int SCREEN_X_MAX = 159;
    localparam int SCREEN_Y_MAX = 119;
    localparam int GLYPH_CODE_W = 6;
    localparam int COLOUR_W     = 6;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT,
        DONE
    } draw_state_t;

    // Screen coordinates are 9 bits wide so cells hanging off the right/bottom edge never wrap.
    function automatic logic within_limit(input logic [8:0] v, input int unsigned lim);
        return 32'(v) <= lim;
    endfunction

endpackage

// File: rtl/char_draw_if.sv
// Request, glyph-lookup and plot signals of the character draw controller.
// The req_bg_colour field exists only when CHAR_DRAW_BG_EN is defined.
interface char_draw_if;
    import char_draw_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic [GLYPH_CODE_W-1:0] req_code;
    logic [7:0]              req_x;
    logic [7:0]              req_y;
    logic [COLOUR_W-1:0]     req_colour;
`ifdef CHAR_DRAW_BG_EN
    logic [COLOUR_W-1:0]     req_bg_colour;
`endif
    logic [GLYPH_CODE_W-1:0] glyph_code;
    logic [7:0]              glyph_dx;
    logic [7:0]              glyph_dy;
    logic                    glyph_on;
    logic                    plot_valid;
    logic                    plot_ready;
    logic [7:0]              plot_x;
    logic [7:0]              plot_y;
    logic [COLOUR_W-1:0]     plot_colour;
    logic                    busy;
    logic                    done;

    // master is the requester/plotter/glyph side, slave is the controller itself.
    modport master (
        output req_valid, req_code, req_x, req_y, req_colour,
`ifdef CHAR_DRAW_BG_EN
        output req_bg_colour,
`endif
        output glyph_on, plot_ready,
        input  req_ready, glyph_code, glyph_dx, glyph_dy,
        input  plot_valid, plot_x, plot_y, plot_colour, busy, done
    );

    modport slave (
        input  req_valid, req_code, req_x, req_y, req_colour,
`ifdef CHAR_DRAW_BG_EN
        input  req_bg_colour,
`endif
        input  glyph_on, plot_ready,
        output req_ready, glyph_code, glyph_dx, glyph_dy,
        output plot_valid, plot_x, plot_y, plot_colour, busy, done
    );

endinterface

// File: rtl/char_cell_counter.sv
// Raster counter over one glyph cell: dx runs fastest, o_last marks the bottom-right position.
module char_cell_counter #(
    parameter int CELL_W = 8,
    parameter int CELL_H = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_advance,
    output logic [7:0] o_dx,
    output logic [7:0] o_dy,
    output logic       o_last
);

    logic [7:0] r_dx;
    logic [7:0] r_dy;
    logic       w_row_end;

    assign w_row_end = (r_dx == 8'(CELL_W - 1));
    assign o_last    = w_row_end && (r_dy == 8'(CELL_H - 1));
    assign o_dx      = r_dx;
    assign o_dy      = r_dy;

    // Advancing past the last position wraps to the origin so the counter never leaves the cell.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dx <= 8'd0;
            r_dy <= 8'd0;
        end else if (i_clear) begin
            r_dx <= 8'd0;
            r_dy <= 8'd0;
        end else if (i_advance) begin
            if (!w_row_end) begin
                r_dx <= r_dx + 8'd1;
            end else begin
                r_dx <= 8'd0;
                r_dy <= o_last ? 8'd0 : r_dy + 8'd1;
            end
        end
    end

endmodule

// File: rtl/char_draw_ctrl.sv
// Turns one draw-character request into clipped pixel writes by scanning a glyph cell.
// Define CHAR_DRAW_BG_EN to also emit unlit pixels in a latched background colour.
module char_draw_ctrl
    import char_draw_pkg::*;
#(
    parameter int CELL_W = DEF_CELL_W,
    parameter int CELL_H = DEF_CELL_H,
    parameter int X_MAX  = SCREEN_X_MAX,
    parameter int Y_MAX  = SCREEN_Y_MAX
) (
    input  logic      clk,
    input  logic      reset,
    char_draw_if.slave bus
);

    draw_state_t             r_state;
    logic [GLYPH_CODE_W-1:0] r_code;
    logic [7:0]              r_x;
    logic [7:0]              r_y;
    logic [COLOUR_W-1:0]     r_colour;
    logic                    r_plot_valid;
    logic [7:0]              r_plot_x;
    logic [7:0]              r_plot_y;
    logic [COLOUR_W-1:0]     r_plot_colour;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_req_ready;

    logic [7:0]              w_dx;
    logic [7:0]              w_dy;
    logic                    w_last;
    logic [8:0]              w_sx;
    logic [8:0]              w_sy;
    logic                    w_visible;
    logic                    w_emit;
    logic                    w_hs;
    logic                    w_clear;
    logic                    w_advance;
    logic [COLOUR_W-1:0]     w_pix_colour;

    char_cell_counter #(
        .CELL_W (CELL_W),
        .CELL_H (CELL_H)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_dx      (w_dx),
        .o_dy      (w_dy),
        .o_last    (w_last)
    );

    assign w_sx      = {1'b0, r_x} + {1'b0, w_dx};
    assign w_sy      = {1'b0, r_y} + {1'b0, w_dy};
    assign w_visible = within_limit(w_sx, X_MAX) && within_limit(w_sy, Y_MAX);
    assign w_hs      = r_plot_valid && bus.plot_ready;
    assign w_clear   = (r_state == IDLE) && bus.req_valid;
    assign w_advance = ((r_state == SCAN) && !w_emit) || ((r_state == EMIT) && w_hs);

`ifdef CHAR_DRAW_BG_EN
    logic [COLOUR_W-1:0] r_bg_colour;

    assign w_emit       = w_visible;
    assign w_pix_colour = bus.glyph_on ? r_colour : r_bg_colour;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bg_colour <= '0;
        end else if (w_clear) begin
            r_bg_colour <= bus.req_bg_colour;
        end
    end
`else
    assign w_emit       = bus.glyph_on && w_visible;
    assign w_pix_colour = r_colour;
`endif

    // The pixel registers are only loaded on SCAN->EMIT, so they stay frozen while the plotter stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_code        <= '0;
            r_x           <= 8'd0;
            r_y           <= 8'd0;
            r_colour      <= '0;
            r_plot_valid  <= 1'b0;
            r_plot_x      <= 8'd0;
            r_plot_y      <= 8'd0;
            r_plot_colour <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_req_ready   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_code      <= bus.req_code;
                        r_x         <= bus.req_x;
                        r_y         <= bus.req_y;
                        r_colour    <= bus.req_colour;
                        r_busy      <= 1'b1;
                        r_req_ready <= 1'b0;
                        r_state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_emit) begin
                        r_plot_x      <= w_sx[7:0];
                        r_plot_y      <= w_sy[7:0];
                        r_plot_colour <= w_pix_colour;
                        r_plot_valid  <= 1'b1;
                        r_state       <= EMIT;
                    end else if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                EMIT: begin
                    if (w_hs) begin
                        r_plot_valid <= 1'b0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.glyph_code  = r_code;
    assign bus.glyph_dx    = w_dx;
    assign bus.glyph_dy    = w_dy;
    assign bus.plot_valid  = r_plot_valid;
    assign bus.plot_x      = r_plot_x;
    assign bus.plot_y      = r_plot_y;
    assign bus.plot_colour = r_plot_colour;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

endmodule

// File: tb/tb_char_draw_ctrl.sv
// Bench for char_draw_ctrl: a 'Q' glyph LUT, a pixel scoreboard and a table of draw requests.
// Also exercises the CHAR_DRAW_BG_EN build when that macro is defined.
module tb_char_draw_ctrl;

    localparam logic [5:0] Q_CODE = 6'd17;
    localparam int NVEC = 9;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [5:0] c;
    } pix_t;

    typedef struct {
        logic [5:0] code;
        logic [7:0] x;
        logic [7:0] y;
        logic [5:0] colour;
        int         expCount;
        int         expBusy;
        logic [7:0] fx;
        logic [7:0] fy;
        logic [7:0] lx;
        logic [7:0] ly;
    } vec_t;

    logic clk;
    logic reset;
    char_draw_if bus ();

    char_draw_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   errCnt = 0;
    int   checkCnt = 0;
    int   plotCnt, busyCnt, doneCnt, modelCnt;
    logic [7:0] firstX, firstY, lastX, lastY;
    pix_t expQ[$];
    vec_t vecs[NVEC];

    function automatic logic [7:0] qRow(input int dy);
        case (dy)
            0:          return 8'h78;
            1, 2, 3, 4: return 8'h84;
            5:          return 8'hA4;
            6:          return 8'h44;
            7:          return 8'h78;
            9:          return 8'h80;
            default:    return 8'h00;
        endcase
    endfunction

    function automatic logic qLit(input logic [5:0] code, input int dx, input int dy);
        logic [7:0] row;
        if (code != Q_CODE || dx > 7 || dy > 9) return 1'b0;
        row = qRow(dy);
        return row[dx];
    endfunction

    assign bus.glyph_on = qLit(bus.glyph_code, int'(bus.glyph_dx), int'(bus.glyph_dy));

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Appends the raster-ordered pixels one request should produce.
    task automatic buildExpected(input logic [5:0] code, input logic [7:0] x, input logic [7:0] y,
                                 input logic [5:0] colour, input logic [5:0] bg);
        for (int dy = 0; dy < 10; dy++) begin
            for (int dx = 0; dx < 8; dx++) begin
                bit   lit, vis, emit;
                pix_t p;
                lit = qLit(code, dx, dy);
                vis = (int'(x) + dx <= 159) && (int'(y) + dy <= 119);
`ifdef CHAR_DRAW_BG_EN
                emit = vis;
`else
                emit = lit && vis;
`endif
                if (emit) begin
                    p.x = 8'(int'(x) + dx);
                    p.y = 8'(int'(y) + dy);
                    p.c = lit ? colour : bg;
                    expQ.push_back(p);
                    modelCnt++;
                end
            end
        end
    endtask

    task automatic clearCounters();
        plotCnt  = 0;
        busyCnt  = 0;
        doneCnt  = 0;
        modelCnt = 0;
        expQ.delete();
    endtask

    task automatic issueRequest(input logic [5:0] code, input logic [7:0] x, input logic [7:0] y,
                                input logic [5:0] colour, input logic [5:0] bg);
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.req_ready) checkOutput("req_ready_timeout", 32'(bus.req_ready), 32'd1);
        bus.req_code   = code;
        bus.req_x      = x;
        bus.req_y      = y;
        bus.req_colour = colour;
`ifdef CHAR_DRAW_BG_EN
        bus.req_bg_colour = bg;
`endif
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic waitDone(input int target);
        int n = 0;
        while (doneCnt < target && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (doneCnt < target) checkOutput("done_timeout", 32'(doneCnt), 32'(target));
    endtask

    // Draws one character; plot_ready is dropped for stallLen cycles while pixel number stallAt is pending.
    task automatic applyStimulus(input logic [5:0] code, input logic [7:0] x, input logic [7:0] y,
                                 input logic [5:0] colour, input logic [5:0] bg,
                                 input int stallAt, input int stallLen);
        int left = stallLen;
        int n = 0;
        clearCounters();
        buildExpected(code, x, y, colour, bg);
        bus.plot_ready = 1'b1;
        issueRequest(code, x, y, colour, bg);
        while (doneCnt == 0 && n < 1000) begin
            if (stallAt >= 0 && plotCnt == stallAt && bus.plot_valid && left > 0) begin
                bus.plot_ready = 1'b0;
                left--;
            end else begin
                bus.plot_ready = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        bus.plot_ready = 1'b1;
        if (doneCnt == 0) checkOutput("draw_timeout", 32'(doneCnt), 32'd1);
        @(posedge clk); #1;
    endtask

    // Scoreboard, hold-stability checks and busy/done accounting, sampled mid-cycle.
    logic       prevHold = 1'b0;
    logic [7:0] prevX, prevY;
    logic [5:0] prevC;
    always @(negedge clk) begin
        if (reset) begin
            prevHold = 1'b0;
        end else begin
            if (prevHold) begin
                checkOutput("hold_valid", 32'(bus.plot_valid), 32'd1);
                checkOutput("hold_x", 32'(bus.plot_x), 32'(prevX));
                checkOutput("hold_y", 32'(bus.plot_y), 32'(prevY));
                checkOutput("hold_colour", 32'(bus.plot_colour), 32'(prevC));
            end
            if (bus.busy && !bus.done) busyCnt++;
            if (bus.done) doneCnt++;
            if (bus.plot_valid && bus.plot_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("extra_plot", 32'(bus.plot_x), 32'hFFFF);
                end else begin
                    pix_t e;
                    e = expQ.pop_front();
                    checkOutput("plot_x", 32'(bus.plot_x), 32'(e.x));
                    checkOutput("plot_y", 32'(bus.plot_y), 32'(e.y));
                    checkOutput("plot_colour", 32'(bus.plot_colour), 32'(e.c));
                end
                if (plotCnt == 0) begin
                    firstX = bus.plot_x;
                    firstY = bus.plot_y;
                end
                lastX = bus.plot_x;
                lastY = bus.plot_y;
                plotCnt++;
            end
            prevHold = bus.plot_valid && !bus.plot_ready;
            prevX = bus.plot_x;
            prevY = bus.plot_y;
            prevC = bus.plot_colour;
        end
    end

    initial begin
        vecs[0] = '{Q_CODE, 8'd10,  8'd20,  6'h3F, 22, 102, 8'd13,  8'd20,  8'd17,  8'd29};
        vecs[1] = '{Q_CODE, 8'd155, 8'd20,  6'h3F, 10, 90,  8'd158, 8'd20,  8'd159, 8'd27};
        vecs[2] = '{Q_CODE, 8'd10,  8'd112, 6'h15, 21, 101, 8'd13,  8'd112, 8'd16,  8'd119};
        vecs[3] = '{Q_CODE, 8'd152, 8'd110, 6'h2A, 22, 102, 8'd155, 8'd110, 8'd159, 8'd119};
        vecs[4] = '{Q_CODE, 8'd0,   8'd0,   6'h01, 22, 102, 8'd3,   8'd0,   8'd7,   8'd9};
        vecs[5] = '{6'd5,   8'd10,  8'd20,  6'h3F, 0,  80,  8'd0,   8'd0,   8'd0,   8'd0};
        vecs[6] = '{Q_CODE, 8'd159, 8'd119, 6'h3F, 0,  80,  8'd0,   8'd0,   8'd0,   8'd0};
        vecs[7] = '{Q_CODE, 8'd200, 8'd200, 6'h3F, 0,  80,  8'd0,   8'd0,   8'd0,   8'd0};
        vecs[8] = '{Q_CODE, 8'd156, 8'd117, 6'h0C, 3,  83,  8'd159, 8'd117, 8'd158, 8'd119};

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_code   = '0;
        bus.req_x      = 8'd0;
        bus.req_y      = 8'd0;
        bus.req_colour = '0;
`ifdef CHAR_DRAW_BG_EN
        bus.req_bg_colour = '0;
`endif
        bus.plot_ready = 1'b1;
        clearCounters();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_plot_valid", 32'(bus.plot_valid), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rst_plot_xy", 32'({bus.plot_x, bus.plot_y}), 32'd0);
        checkOutput("rst_plot_colour", 32'(bus.plot_colour), 32'd0);
        checkOutput("rst_glyph", 32'({bus.glyph_code, bus.glyph_dx, bus.glyph_dy}), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].code, vecs[i].x, vecs[i].y, vecs[i].colour, 6'h00, -1, 0);
            checkOutput($sformatf("v%0d_done_pulses", i), 32'(doneCnt), 32'd1);
            checkOutput($sformatf("v%0d_missing", i), 32'(expQ.size()), 32'd0);
`ifndef CHAR_DRAW_BG_EN
            checkOutput($sformatf("v%0d_count", i), 32'(plotCnt), 32'(vecs[i].expCount));
            checkOutput($sformatf("v%0d_busy", i), 32'(busyCnt), 32'(vecs[i].expBusy));
            if (vecs[i].expCount > 0) begin
                checkOutput($sformatf("v%0d_first", i), 32'({firstX, firstY}), 32'({vecs[i].fx, vecs[i].fy}));
                checkOutput($sformatf("v%0d_last", i), 32'({lastX, lastY}), 32'({vecs[i].lx, vecs[i].ly}));
            end
`else
            checkOutput($sformatf("v%0d_count", i), 32'(plotCnt), 32'(modelCnt));
`endif
        end

        // Plotter stalls on the third pixel; the hold checks in the monitor cover stability.
        applyStimulus(Q_CODE, 8'd10, 8'd20, 6'h3F, 6'h00, 2, 5);
        checkOutput("stall_count", 32'(plotCnt), 32'(modelCnt));
        checkOutput("stall_missing", 32'(expQ.size()), 32'd0);
        checkOutput("stall_done", 32'(doneCnt), 32'd1);

        // A second request held high while busy must wait until the controller is idle again.
        clearCounters();
        buildExpected(Q_CODE, 8'd10, 8'd20, 6'h3F, 6'h00);
        buildExpected(Q_CODE, 8'd0, 8'd0, 6'h15, 6'h00);
        issueRequest(Q_CODE, 8'd10, 8'd20, 6'h3F, 6'h00);
        bus.req_x      = 8'd0;
        bus.req_y      = 8'd0;
        bus.req_colour = 6'h15;
        bus.req_valid  = 1'b1;
        checkOutput("busy_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("busy_flag", 32'(bus.busy), 32'd1);
        waitDone(1);
        checkOutput("idle_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("idle_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checkOutput("accept_busy", 32'(bus.busy), 32'd1);
        checkOutput("accept_req_ready", 32'(bus.req_ready), 32'd0);
        waitDone(2);
        @(posedge clk); #1;
        checkOutput("b2b_count", 32'(plotCnt), 32'(modelCnt));
        checkOutput("b2b_missing", 32'(expQ.size()), 32'd0);
        checkOutput("b2b_done", 32'(doneCnt), 32'd2);

        // Reset while a pixel is pending, then draw again.
        clearCounters();
        bus.plot_ready = 1'b0;
        issueRequest(Q_CODE, 8'd10, 8'd20, 6'h3F, 6'h00);
        for (int n = 0; n < 200 && !bus.plot_valid; n++) begin
            @(posedge clk); #1;
        end
        checkOutput("pre_rst_valid", 32'(bus.plot_valid), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("emit_rst_valid", 32'(bus.plot_valid), 32'd0);
        checkOutput("emit_rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("emit_rst_done", 32'(bus.done), 32'd0);
        checkOutput("emit_rst_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.plot_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        applyStimulus(Q_CODE, 8'd10, 8'd20, 6'h3F, 6'h00, -1, 0);
        checkOutput("post_rst_count", 32'(plotCnt), 32'(modelCnt));
        checkOutput("post_rst_missing", 32'(expQ.size()), 32'd0);
        checkOutput("post_rst_done", 32'(doneCnt), 32'd1);
`ifndef CHAR_DRAW_BG_EN
        checkOutput("post_rst_first", 32'({firstX, firstY}), 32'({8'd13, 8'd20}));
        checkOutput("post_rst_busy", 32'(busyCnt), 32'd102);
`endif

`ifdef CHAR_DRAW_BG_EN
        // Background fill: every cell position is plotted.
        applyStimulus(Q_CODE, 8'd0, 8'd0, 6'h3F, 6'h01, -1, 0);
        checkOutput("bg_count", 32'(plotCnt), 32'd80);
        checkOutput("bg_busy", 32'(busyCnt), 32'd160);
        checkOutput("bg_missing", 32'(expQ.size()), 32'd0);
        checkOutput("bg_first", 32'({firstX, firstY}), 32'd0);
        checkOutput("bg_last", 32'({lastX, lastY}), 32'({8'd7, 8'd9}));
`endif

        $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
        $finish;
    end

endmodule
